// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer.
package bit_serializer_pkg;

  // Serializer FSM states; StParity is only reachable when SERIALIZER_PARITY_EN is defined.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2
  } state_e;

  // Width of a counter that can hold the values 0..data_w.
  function automatic int unsigned bit_cnt_w(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Parallel-load shift register for the serializer. It holds the word in flight and exposes
// the bit that follows the one currently driven on the serial output.
module ser_shift_reg #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic              next_bit
);

  logic [DATA_W-1:0] sr_q, sr_d;

  // Load has priority over shift. The register rotates rather than shifts in zeros, so
  // every bit stays observable.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift) begin
      sr_d = MSB_FIRST ? {sr_q[DATA_W-2:0], sr_q[DATA_W-1]} : {sr_q[0], sr_q[DATA_W-1:1]};
    end
  end

  // The head bit is already registered in the top, so look one position past it.
  assign next_bit = MSB_FIRST ? sr_q[DATA_W-2] : sr_q[1];

  // State register for the held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready input handshake and registered serial outputs.
// Optional feature: define SERIALIZER_PARITY_EN to append one even-parity bit to each word.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              word_done
);

  localparam int unsigned      CntW      = bit_cnt_w(DATA_W);
  localparam logic [CntW-1:0]  LastIdx   = CntW'(DATA_W - 1);
`ifndef SERIALIZER_PARITY_EN
  localparam logic [CntW-1:0]  PenultIdx = CntW'(DATA_W - 2);
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ser_out_q, ser_out_d;
  logic            ser_valid_q, ser_valid_d;
  logic            word_done_q, word_done_d;
`ifdef SERIALIZER_PARITY_EN
  logic            par_q, par_d;
`endif

  logic accept;
  logic last_data;
  logic first_bit;
  logic sr_load;
  logic sr_shift;
  logic sr_next_bit;

  // cnt_q is the index of the data bit currently on ser_out.
  assign last_data = (state_q == StShift) && (cnt_q == LastIdx);
`ifdef SERIALIZER_PARITY_EN
  assign in_ready  = (state_q == StIdle) || (state_q == StParity);
`else
  assign in_ready  = (state_q == StIdle) || last_data;
`endif
  assign accept    = in_valid && in_ready;
  assign first_bit = MSB_FIRST ? in_data[DATA_W-1] : in_data[0];

  ser_shift_reg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (in_data),
    .next_bit  (sr_next_bit)
  );

  // Next-state logic: advance through the data bits, then optionally parity; an accept in
  // the final cycle of a word starts the next word with no idle gap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ser_out_d   = IDLE_BIT;
    ser_valid_d = 1'b0;
    word_done_d = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_d       = par_q;
`endif

    case (state_q)
      StIdle: begin
        cnt_d = '0;
      end
      StShift: begin
        if (!last_data) begin
          sr_shift    = 1'b1;
          cnt_d       = cnt_q + CntW'(1);
          ser_out_d   = sr_next_bit;
          ser_valid_d = 1'b1;
`ifndef SERIALIZER_PARITY_EN
          word_done_d = (cnt_q == PenultIdx);
`endif
        end else begin
          cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
          state_d     = StParity;
          ser_out_d   = par_q;
          ser_valid_d = 1'b1;
          word_done_d = 1'b1;
`else
          state_d     = StIdle;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      StParity: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
`endif
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // accept is only possible in the cycles handled above as word-final or idle.
    if (accept) begin
      state_d     = StShift;
      cnt_d       = '0;
      ser_out_d   = first_bit;
      ser_valid_d = 1'b1;
      word_done_d = 1'b0;
      sr_load     = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      par_d       = ^in_data;
`endif
    end
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
`ifdef SERIALIZER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer; honours SERIALIZER_PARITY_EN when defined.
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned LA = 4 + PAR;
  localparam int unsigned LC = 8 + PAR;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] a_in_data = '0, b_in_data = '0;
  logic [7:0] c_in_data = '0;
  logic a_in_valid = 1'b0, b_in_valid = 1'b0, c_in_valid = 1'b0;
  logic a_in_ready, a_ser_out, a_ser_valid, a_word_done;
  logic b_in_ready, b_ser_out, b_ser_valid, b_word_done;
  logic c_in_ready, c_ser_out, c_ser_valid, c_word_done;

  bit_serializer #(.DATA_W(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ser_out(a_ser_out), .ser_valid(a_ser_valid), .word_done(a_word_done));

  bit_serializer #(.DATA_W(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ser_out(b_ser_out), .ser_valid(b_ser_valid), .word_done(b_word_done));

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .ser_out(c_ser_out), .ser_valid(c_ser_valid), .word_done(c_word_done));

  // Downstream 1011 pattern detector on the u_a stream (sticky hit flag).
  logic [3:0] det_sh  = '0;
  logic       det_hit = 1'b0;
  always @(posedge clk) begin
    if (a_ser_valid) begin
      if ({det_sh[2:0], a_ser_out} == 4'b1011) det_hit <= 1'b1;
      det_sh <= {det_sh[2:0], a_ser_out};
    end
  end

  // Expected bit idx of a word: data bits in the given order, then even parity at idx == w.
  function automatic logic exp_bit(input logic [31:0] word, input int unsigned w,
                                   input bit msb, input int unsigned idx);
    logic p;
    p = 1'b0;
    for (int i = 0; i < int'(w); i++) p = p ^ word[i];
    if (idx >= w) return p;
    return msb ? word[w-1-idx] : word[idx];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    checks += 12;
    if (a_ser_valid !== 1'b0) begin failures++; $display("FAIL rst_a_valid got=%b exp=0", a_ser_valid); end
    if (a_word_done !== 1'b0) begin failures++; $display("FAIL rst_a_done got=%b exp=0", a_word_done); end
    if (a_ser_out !== 1'b0) begin failures++; $display("FAIL rst_a_out got=%b exp=0", a_ser_out); end
    if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_a_ready got=%b exp=1", a_in_ready); end
    if (b_ser_valid !== 1'b0) begin failures++; $display("FAIL rst_b_valid got=%b exp=0", b_ser_valid); end
    if (b_word_done !== 1'b0) begin failures++; $display("FAIL rst_b_done got=%b exp=0", b_word_done); end
    if (b_ser_out !== 1'b0) begin failures++; $display("FAIL rst_b_out got=%b exp=0", b_ser_out); end
    if (b_in_ready !== 1'b1) begin failures++; $display("FAIL rst_b_ready got=%b exp=1", b_in_ready); end
    if (c_ser_valid !== 1'b0) begin failures++; $display("FAIL rst_c_valid got=%b exp=0", c_ser_valid); end
    if (c_word_done !== 1'b0) begin failures++; $display("FAIL rst_c_done got=%b exp=0", c_word_done); end
    if (c_ser_out !== 1'b1) begin failures++; $display("FAIL rst_c_out got=%b exp=1", c_ser_out); end
    if (c_in_ready !== 1'b1) begin failures++; $display("FAIL rst_c_ready got=%b exp=1", c_in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_msb_first;
    logic e;
    checks++;
    if (det_hit !== 1'b0) begin failures++; $display("FAIL det_pre got=%b exp=0", det_hit); end
    a_in_data  = 4'b1011;
    a_in_valid = 1'b1;
    checks++;
    if (a_in_ready !== 1'b1) begin failures++; $display("FAIL msb_ready0 got=%b exp=1", a_in_ready); end
    for (int k = 1; k <= int'(LA); k++) begin
      step();
      if (k == 1) begin a_in_valid = 1'b0; a_in_data = 4'b0000; end
      e = exp_bit(32'hB, 4, 1'b1, k - 1);
      checks += 4;
      if (a_ser_out !== e) begin failures++; $display("FAIL msb_out k=%0d got=%b exp=%b", k, a_ser_out, e); end
      if (a_ser_valid !== 1'b1) begin failures++; $display("FAIL msb_valid k=%0d got=%b exp=1", k, a_ser_valid); end
      if (a_word_done !== (k == int'(LA))) begin
        failures++; $display("FAIL msb_done k=%0d got=%b exp=%b", k, a_word_done, k == int'(LA)); end
      if (a_in_ready !== (k == int'(LA))) begin
        failures++; $display("FAIL msb_ready k=%0d got=%b exp=%b", k, a_in_ready, k == int'(LA)); end
    end
    step();
    checks += 3;
    if (a_ser_valid !== 1'b0) begin failures++; $display("FAIL msb_idle_valid got=%b exp=0", a_ser_valid); end
    if (a_ser_out !== 1'b0) begin failures++; $display("FAIL msb_idle_out got=%b exp=0", a_ser_out); end
    if (det_hit !== 1'b1) begin failures++; $display("FAIL det_1011 got=%b exp=1", det_hit); end
  endtask

  task automatic test_lsb_first;
    logic e;
    b_in_data  = 4'b1011;
    b_in_valid = 1'b1;
    for (int k = 1; k <= int'(LB()); k++) begin
      step();
      if (k == 1) begin b_in_valid = 1'b0; b_in_data = 4'b0100; end
      e = exp_bit(32'hB, 4, 1'b0, k - 1);
      checks += 3;
      if (b_ser_out !== e) begin failures++; $display("FAIL lsb_out k=%0d got=%b exp=%b", k, b_ser_out, e); end
      if (b_ser_valid !== 1'b1) begin failures++; $display("FAIL lsb_valid k=%0d got=%b exp=1", k, b_ser_valid); end
      if (b_word_done !== (k == int'(LA))) begin
        failures++; $display("FAIL lsb_done k=%0d got=%b exp=%b", k, b_word_done, k == int'(LA)); end
    end
    step();
    checks++;
    if (b_ser_valid !== 1'b0) begin failures++; $display("FAIL lsb_idle_valid got=%b exp=0", b_ser_valid); end
  endtask

  function automatic int unsigned LB();
    return LA;
  endfunction

  task automatic test_back_to_back;
    logic e;
    c_in_data  = 8'hA5;
    c_in_valid = 1'b1;
    for (int k = 0; k <= 2 * int'(LC); k++) begin
      if (k > 0) begin
        if (k <= int'(LC)) e = exp_bit(32'hA5, 8, 1'b1, k - 1);
        else e = exp_bit(32'h3C, 8, 1'b1, k - 1 - LC);
        checks += 3;
        if (c_ser_out !== e) begin failures++; $display("FAIL b2b_out k=%0d got=%b exp=%b", k, c_ser_out, e); end
        if (c_ser_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, c_ser_valid); end
        if (c_word_done !== (k == int'(LC) || k == 2 * int'(LC))) begin
          failures++; $display("FAIL b2b_done k=%0d got=%b", k, c_word_done); end
      end
      checks++;
      if (c_in_ready !== (k == 0 || k == int'(LC) || k == 2 * int'(LC))) begin
        failures++; $display("FAIL b2b_ready k=%0d got=%b", k, c_in_ready); end
      if (k == 1) c_in_data = 8'h3C;
      if (k == int'(LC) + 1) c_in_valid = 1'b0;
      if (k < 2 * int'(LC)) step();
    end
    step();
    checks += 2;
    if (c_ser_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", c_ser_valid); end
    if (c_ser_out !== 1'b1) begin failures++; $display("FAIL b2b_end_out got=%b exp=1", c_ser_out); end
  endtask

  task automatic test_idle_gap;
    c_in_data  = 8'h5A;
    c_in_valid = 1'b1;
    step();
    c_in_valid = 1'b0;
    for (int k = 2; k <= int'(LC) + 3; k++) begin
      step();
      if (k > int'(LC)) begin
        checks += 4;
        if (c_ser_valid !== 1'b0) begin failures++; $display("FAIL idle_valid k=%0d got=%b exp=0", k, c_ser_valid); end
        if (c_ser_out !== 1'b1) begin failures++; $display("FAIL idle_out k=%0d got=%b exp=1", k, c_ser_out); end
        if (c_word_done !== 1'b0) begin failures++; $display("FAIL idle_done k=%0d got=%b exp=0", k, c_word_done); end
        if (c_in_ready !== 1'b1) begin failures++; $display("FAIL idle_ready k=%0d got=%b exp=1", k, c_in_ready); end
      end
    end
  endtask

  task automatic test_reset_mid;
    c_in_data  = 8'hFF;
    c_in_valid = 1'b1;
    step();
    c_in_valid = 1'b0;
    step();
    checks += 2;
    if (c_ser_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid got=%b exp=1", c_ser_valid); end
    if (c_ser_out !== 1'b1) begin failures++; $display("FAIL rmid_pre_out got=%b exp=1", c_ser_out); end
    rst = 1'b1;
    #1;
    checks += 4;
    if (c_ser_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", c_ser_valid); end
    if (c_ser_out !== 1'b1) begin failures++; $display("FAIL rmid_out got=%b exp=1", c_ser_out); end
    if (c_word_done !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b exp=0", c_word_done); end
    if (c_in_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", c_in_ready); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (c_ser_valid !== 1'b0) begin failures++; $display("FAIL rmid_after k=%0d got=%b exp=0", k, c_ser_valid); end
    end
  endtask

  task automatic test_first_after_reset;
    logic e;
    rst = 1'b1;
    step();
    c_in_data  = 8'h81;
    c_in_valid = 1'b1;
    rst        = 1'b0;
    for (int k = 1; k <= int'(LC) + 1; k++) begin
      step();
      if (k == 1) c_in_valid = 1'b0;
      e = (k <= int'(LC)) ? exp_bit(32'h81, 8, 1'b1, k - 1) : 1'b1;
      checks += 2;
      if (c_ser_out !== e) begin failures++; $display("FAIL far_out k=%0d got=%b exp=%b", k, c_ser_out, e); end
      if (c_ser_valid !== (k <= int'(LC))) begin
        failures++; $display("FAIL far_valid k=%0d got=%b exp=%b", k, c_ser_valid, k <= int'(LC)); end
    end
  endtask

  task automatic test_word_07;
    logic e;
    c_in_data  = 8'h07;
    c_in_valid = 1'b1;
    for (int k = 1; k <= int'(LC) + 1; k++) begin
      step();
      if (k == 1) c_in_valid = 1'b0;
      e = (k <= int'(LC)) ? exp_bit(32'h07, 8, 1'b1, k - 1) : 1'b1;
      checks += 3;
      if (c_ser_out !== e) begin failures++; $display("FAIL w07_out k=%0d got=%b exp=%b", k, c_ser_out, e); end
      if (c_ser_valid !== (k <= int'(LC))) begin
        failures++; $display("FAIL w07_valid k=%0d got=%b exp=%b", k, c_ser_valid, k <= int'(LC)); end
      if (c_word_done !== (k == int'(LC))) begin
        failures++; $display("FAIL w07_done k=%0d got=%b exp=%b", k, c_word_done, k == int'(LC)); end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_idle_gap();
    test_reset_mid();
    test_first_after_reset();
    test_word_07();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter: DATA_W, default 8, parallel word width (2..32).
REQ-002 SHALL have parameter: MSB_FIRST, default 1, 1 = shift MSB first, 0 = LSB first.
REQ-003 SHALL have parameter: IDLE_BIT, default 0, level driven on ser_out when no bit is being sent.
REQ-004 SHALL have port: clk  input  1  clock, all state updated on rising edge.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: in_data  input  DATA_W  parallel word to serialize.
REQ-007 SHALL have port: in_valid  input  1  in_data holds a word.
REQ-008 SHALL have port: in_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL have port: ser_out  output  1  serial bit stream to the downstream pattern detector.
REQ-010 SHALL have port: ser_valid  output  1  ser_out carries a live bit this cycle.
REQ-011 SHALL have port: word_done  output  1  one-cycle pulse on the last bit of each word.

Function
REQ-012 SHALL accept a word only on a rising edge where in_valid && in_ready.
REQ-013 SHALL implement states IDLE and SHIFT (plus PARITY when enabled): IDLE->SHIFT on accept; SHIFT->IDLE after last bit with no new accept; SHIFT->SHIFT on last bit with accept.
REQ-014 SHALL drive in_ready combinationally high in IDLE and during the final bit cycle of a word; low otherwise.
REQ-015 SHALL register ser_out/ser_valid: first bit of an accepted word appears in the cycle after the accepting edge (latency 1).
REQ-016 SHALL emit exactly DATA_W data bits, one per clock, order set by MSB_FIRST, with no gap between bits.
REQ-017 SHALL support back-to-back words with zero idle cycles when in_valid is held high.
REQ-018 SHALL hold ser_out = IDLE_BIT and ser_valid = 0 whenever no word is in flight.
REQ-019 SHALL capture in_data at accept; in_data changes afterwards SHALL NOT affect the word in flight.
REQ-020 SHALL count bits with a counter of width clog2(DATA_W+1), wrapping to 0 at word end.
REQ-021 SHALL assert word_done coincident with ser_valid on the final bit (parity bit when enabled).

Reset
REQ-022 SHALL on rst force state IDLE, bit counter 0, ser_out = IDLE_BIT, ser_valid 0, word_done 0; in_ready reads 1.
REQ-023 SHALL discard a partially sent word on rst mid-operation; no remaining bits SHALL be emitted after release.
REQ-024 SHALL accept a word on the first rising edge after rst deassertion.

Configuration
REQ-025 SHALL, with SERIALIZER_PARITY_EN defined, append one even-parity bit (XOR of data bits) after the data bits, with ser_valid high; in_ready and word_done SHALL move to the parity cycle.
REQ-026 SHALL, without SERIALIZER_PARITY_EN, emit exactly DATA_W bits per word and omit the PARITY state.

Structure
REQ-027 SHALL place the state enum (IDLE, SHIFT, PARITY) and the bit-counter width function in shared package bit_serializer_pkg.
REQ-028 SHALL instantiate one sub-module, ser_shift_reg (parallel load, 1-bit shift, direction per MSB_FIRST); FSM and counter stay in the top.

Verification
REQ-029 SHALL cover: DATA_W=4, MSB_FIRST=1, accept 4'b1011 -> ser_out 1,0,1,1 on cycles 1-4 with ser_valid high; word_done on cycle 4; downstream 1011 detector fires.
REQ-030 SHALL cover: MSB_FIRST=0, accept 4'b1011 -> ser_out 1,1,0,1.
REQ-031 SHALL cover: DATA_W=8, in_valid held with 8'hA5 then 8'h3C -> 16 contiguous valid bits 10100101_00111100; in_ready high only in cycles 0, 8, 16.
REQ-032 SHALL cover: in_valid low after one word -> ser_valid 0, ser_out = IDLE_BIT from cycle 9 on.
REQ-033 SHALL cover: rst asserted after 2 bits of 8'hFF -> ser_valid 0 immediately; after release, no further bits until a new accept.
REQ-034 SHALL cover: SERIALIZER_PARITY_EN, DATA_W=8, word 8'h07 -> 9 valid bits, 9th bit = 1, word_done on the 9th bit.
